mem_lsu_stage: RTL
==================

// Module: mem_lsu_stage
// PURPOSE
//  Parametrised MEM pipeline stage for the 5-stage MIPS core: EX->MEM pipeline register with stall/flush,
//  variable-latency data-SRAM read handshake, byte/half/word load extraction with sign/zero extension,
//  misalignment detect, load timeout, and MEM->ID forwarding outputs. Sits between EX and WB.
// PARAMETERS
//  PC_W       32  width of pc field carried down the pipe
//  STALL_W     6  width of stall bus
//  STALL_IDX   3  stall bit gating this stage's input register; STALL_IDX+1 gates the WB register
//  TIMEOUT   255  max cycles waiting for rvalid; 0 disables timeout
// PORTS
//  clk              in   1            clock
//  rst              in   1            synchronous, active-high reset
//  flush            in   1            squash stage contents
//  stall            in   STALL_W      1 = Stop, 0 = NoStop
//  ex_to_mem_bus    in   PC_W+47      {pc, mem_en, mem_wen[3:0], load_type[2:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}
//  data_sram_rdata  in   32           read data from data SRAM
//  data_sram_rvalid in   1            read data valid; meaningful only in WAIT
//  mem_to_wb_bus    out  PC_W+38      {pc, rf_we_eff, rf_waddr, rf_wdata}
//  mem_wreg         out  1            forwarding: rf_we_eff
//  mem_waddr        out  5            forwarding: rf_waddr
//  mem_wdata        out  32           forwarding: rf_wdata
//  stallreq         out  1            request pipeline stall (load data outstanding)
//  mem_err          out  1            load timed out (ERR state)
//  mem_misalign     out  1            held load/store violates alignment
// BEHAVIOUR
//  Register priority: rst -> 0; else flush -> 0; else stall[IDX]=1 & stall[IDX+1]=0 -> 0 (bubble);
//   else stall[IDX]=0 -> load ex_to_mem_bus; else hold. "Advance" = any write of the register.
//  is_load = mem_en & (mem_wen==0) & sel_rf_res. load_type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU;
//   others are treated as LW.
//  Extraction uses a = ex_result[1:0]: LB/LBU select byte a; LH/LHU select half a[1]; sign- or zero-extend to 32.
//  mem_misalign = mem_en & ((LW-type & a!=0) | (LH/LHU & a[0]) | (store wen 4'b1111 & a!=0)); combinational.
//  FSM {IDLE, WAIT, DONE, ERR}; reset/flush -> IDLE, cnt=0, rbuf=0.
//   On advance: next = WAIT if the new content is a non-misaligned load, else IDLE; cnt=0.
//   WAIT & rvalid & no advance -> DONE, rbuf <= data_sram_rdata.
//   WAIT & !rvalid -> cnt+1; if TIMEOUT!=0 & cnt==TIMEOUT-1 -> ERR.
//   DONE/ERR hold until advance.
//  stallreq = (state==WAIT) & !data_sram_rvalid; combinational, same cycle.
//  Load data source: WAIT with rvalid -> extract(data_sram_rdata) (zero added latency); DONE -> extract(rbuf).
//  rf_wdata = sel_rf_res ? load data : ex_result.
//  rf_we_eff = rf_we & !mem_misalign & !(is_load & state in {WAIT w/o rvalid, ERR}).
//  mem_err = (state==ERR). All outputs are 0 after reset, since the register is zero.
//  Simultaneous: flush beats rvalid; rvalid in the same cycle as advance is used for the departing load.
// TESTING
//  LW @0x10, rvalid same cycle rdata=0xDEADBEEF -> stallreq=0, rf_wdata=0xDEADBEEF, rf_we=1 that cycle.
//  LB a=3 rdata=0x80FFFFFF, rvalid after 3 cycles -> stallreq=1 for 3 cycles, then rf_wdata=0xFFFFFF80.
//  LHU a=2 rdata=0x8001_1234 while stall[4]=1 for 2 cycles -> DONE holds rbuf, rf_wdata=0x00008001.
//  TIMEOUT=4, no rvalid -> stallreq=1 for 4 cycles, then mem_err=1, stallreq=0, rf_we_eff=0.
//  LH a=1 -> mem_misalign=1, stallreq=0, rf_we_eff=0; flush mid-WAIT -> next cycle IDLE, bus all zero.

Source files
------------

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: EX->MEM register with stall/flush, variable-latency
// data-SRAM read handshake, sub-word load extraction, misalignment detect,
// load timeout and MEM->ID forwarding outputs.
module mem_lsu_stage #(
    parameter int PC_W      = 32,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [STALL_W-1:0]   stall,
    input  logic [PC_W+46:0]     ex_to_mem_bus,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 data_sram_rvalid,
    output logic [PC_W+37:0]     mem_to_wb_bus,
    output logic                 mem_wreg,
    output logic [4:0]           mem_waddr,
    output logic [31:0]          mem_wdata,
    output logic                 stallreq,
    output logic                 mem_err,
    output logic                 mem_misalign
);

    localparam int IN_W  = PC_W + 47;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TO_EN = (TIMEOUT > 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // A load writes the register file from memory and performs no byte writes.
    function automatic logic is_load_f(input logic en, input logic [3:0] wen, input logic sel);
        return en & (wen == 4'b0000) & sel;
    endfunction

    // Alignment check; the load-size terms only apply to read accesses.
    function automatic logic misalign_f(input logic en, input logic [3:0] wen,
                                        input logic [2:0] lt, input logic [1:0] a);
        logic half_v;
        logic word_v;
        logic rd_v;
        case (lt)
            LT_LB, LT_LBU: begin half_v = 1'b0; word_v = 1'b0; end
            LT_LH, LT_LHU: begin half_v = 1'b1; word_v = 1'b0; end
            default:       begin half_v = 1'b0; word_v = 1'b1; end
        endcase
        rd_v = (wen == 4'b0000);
        return en & ((rd_v & word_v & (a != 2'b00)) |
                     (rd_v & half_v & a[0]) |
                     ((wen == 4'b1111) & (a != 2'b00)));
    endfunction

    // Select byte/half by address and sign- or zero-extend to 32 bits.
    function automatic logic [31:0] extract_f(input logic [2:0] lt, input logic [1:0] a,
                                              input logic [31:0] d);
        logic [7:0]  b_v;
        logic [15:0] h_v;
        case (a)
            2'd0:    b_v = d[7:0];
            2'd1:    b_v = d[15:8];
            2'd2:    b_v = d[23:16];
            2'd3:    b_v = d[31:24];
            default: b_v = d[7:0];
        endcase
        h_v = a[1] ? d[31:16] : d[15:0];
        case (lt)
            LT_LB:   return {{24{b_v[7]}}, b_v};
            LT_LBU:  return {24'h000000, b_v};
            LT_LH:   return {{16{h_v[15]}}, h_v};
            LT_LHU:  return {16'h0000, h_v};
            default: return d;
        endcase
    endfunction

    logic [IN_W-1:0]  pipe_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      rbuf_r;

    // Held instruction fields
    logic [PC_W-1:0] pc_s;
    logic            mem_en_s;
    logic [3:0]      mem_wen_s;
    logic [2:0]      load_type_s;
    logic            sel_rf_res_s;
    logic            rf_we_s;
    logic [4:0]      rf_waddr_s;
    logic [31:0]     ex_result_s;

    assign pc_s         = pipe_r[IN_W-1:47];
    assign mem_en_s     = pipe_r[46];
    assign mem_wen_s    = pipe_r[45:42];
    assign load_type_s  = pipe_r[41:39];
    assign sel_rf_res_s = pipe_r[38];
    assign rf_we_s      = pipe_r[37];
    assign rf_waddr_s   = pipe_r[36:32];
    assign ex_result_s  = pipe_r[31:0];

    logic bubble_s;
    logic load_s;
    logic new_wait_s;

    assign bubble_s = stall[STALL_IDX] & ~stall[STALL_IDX+1];
    assign load_s   = ~stall[STALL_IDX];
    assign new_wait_s = load_s
                      & is_load_f(ex_to_mem_bus[46], ex_to_mem_bus[45:42], ex_to_mem_bus[38])
                      & ~misalign_f(ex_to_mem_bus[46], ex_to_mem_bus[45:42],
                                    ex_to_mem_bus[41:39], ex_to_mem_bus[1:0]);

    // EX->MEM pipeline register: reset, flush, bubble, load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_r <= '0;
        end else if (flush) begin
            pipe_r <= '0;
        end else if (bubble_s) begin
            pipe_r <= '0;
        end else if (load_s) begin
            pipe_r <= ex_to_mem_bus;
        end else begin
            pipe_r <= pipe_r;
        end
    end

    // Load handshake FSM with timeout counter and read-data buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            rbuf_r  <= 32'h0000_0000;
        end else if (bubble_s || load_s) begin
            state_r <= new_wait_s ? ST_WAIT : ST_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (data_sram_rvalid) begin
                        state_r <= ST_DONE;
                        rbuf_r  <= data_sram_rdata;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (TO_EN && (cnt_r == CNT_LAST)) begin
                            state_r <= ST_ERR;
                        end
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    logic        is_load_s;
    logic        misalign_s;
    logic [31:0] load_data_s;
    logic [31:0] rf_wdata_s;
    logic        load_blocked_s;
    logic        rf_we_eff_s;
    logic        waiting_s;

    assign is_load_s  = is_load_f(mem_en_s, mem_wen_s, sel_rf_res_s);
    assign misalign_s = misalign_f(mem_en_s, mem_wen_s, load_type_s, ex_result_s[1:0]);
    assign waiting_s  = (state_r == ST_WAIT) & ~data_sram_rvalid;

    // Load data: live SRAM data on arrival, buffered data once done.
    always_comb begin
        load_data_s = 32'h0000_0000;
        if ((state_r == ST_WAIT) && data_sram_rvalid) begin
            load_data_s = extract_f(load_type_s, ex_result_s[1:0], data_sram_rdata);
        end else if (state_r == ST_DONE) begin
            load_data_s = extract_f(load_type_s, ex_result_s[1:0], rbuf_r);
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    // Write-back data and effective write enable.
    always_comb begin
        rf_wdata_s     = sel_rf_res_s ? load_data_s : ex_result_s;
        load_blocked_s = is_load_s & (waiting_s | (state_r == ST_ERR));
        rf_we_eff_s    = rf_we_s & ~misalign_s & ~load_blocked_s;
    end

    assign mem_to_wb_bus = {pc_s, rf_we_eff_s, rf_waddr_s, rf_wdata_s};
    assign mem_wreg      = rf_we_eff_s;
    assign mem_waddr     = rf_waddr_s;
    assign mem_wdata     = rf_wdata_s;
    assign stallreq      = waiting_s;
    assign mem_err       = (state_r == ST_ERR);
    assign mem_misalign  = misalign_s;

endmodule
